// File: rtl/snoop_bus_arbiter.sv
// snoop_bus_arbiter: round-robin snoop-bus controller; grants one coherence request,
// broadcasts the snoop, sequences cache or memory data, and returns the MOESI install state.
module snoop_bus_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W = 64,
  localparam int IDX_W = $clog2(NUM_CORES)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CORES-1:0]        req_valid,
  input  logic [NUM_CORES*2-1:0]      req_type,
  input  logic [NUM_CORES*ADDR_W-1:0] req_addr,
  output logic [NUM_CORES-1:0]        req_grant,
  output logic                        snoop_valid,
  output logic [1:0]                  snoop_type,
  output logic [ADDR_W-1:0]           snoop_addr,
  output logic [NUM_CORES-1:0]        snoop_target,
  input  logic [NUM_CORES-1:0]        snp_provide_data,
  input  logic [NUM_CORES-1:0]        snp_hit,
  output logic                        data_from_cache,
  output logic [IDX_W-1:0]            data_src,
  output logic                        mem_req,
  output logic [ADDR_W-1:0]           mem_addr,
  input  logic                        mem_done,
  output logic [NUM_CORES-1:0]        resp_valid,
  output logic [2:0]                  resp_state,
  output logic                        protocol_err,
  output logic                        busy
);
  typedef enum logic [2:0] {IDLE, SNOOP, XFER, MEM, RESP} state_e;
  state_e state_q, state_d;
  logic [IDX_W-1:0] rr_q, rr_d, win_q, win_d, src_q, src_d, pick, low, j;
  logic [1:0] type_q, type_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic shr_q, shr_d, perr_q, perr_d, found;
  logic [NUM_CORES-1:0] win_oh, elig, prov, shr;
  logic [1:0] typ [NUM_CORES];
  logic [ADDR_W-1:0] adr [NUM_CORES];
  int k;
  assign win_oh = {{(NUM_CORES-1){1'b0}}, 1'b1} << win_q;
  assign prov = snp_provide_data & ~win_oh;
  assign shr = snp_hit & ~win_oh;
  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      typ[i] = req_type[2*i +: 2];
      adr[i] = req_addr[ADDR_W*i +: ADDR_W];
      elig[i] = req_valid[i] & |req_type[2*i +: 2];
    end
  end
  // Scan from the highest offset down so the core nearest rr_q is the last one written.
  always_comb begin
    found = 1'b0;
    pick = '0;
    k = 0;
    j = '0;
    for (int i = NUM_CORES-1; i >= 0; i--) begin
      k = int'(rr_q) + i;
      k = (k >= NUM_CORES) ? k - NUM_CORES : k;
      j = IDX_W'(k);
      if (elig[j]) begin
        found = 1'b1;
        pick = j;
      end
    end
  end
  always_comb begin
    low = '0;
    for (int i = NUM_CORES-1; i >= 0; i--)
      if (prov[i]) low = IDX_W'(i);
  end
  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    win_d = win_q;
    type_d = type_q;
    addr_d = addr_q;
    shr_d = shr_q;
    src_d = src_q;
    perr_d = 1'b0;
    case (state_q)
      IDLE: if (found) begin
        win_d = pick;
        type_d = typ[pick];
        addr_d = adr[pick];
        rr_d = (pick == IDX_W'(NUM_CORES-1)) ? '0 : pick + 1'b1;
        state_d = SNOOP;
      end
      SNOOP: begin
        shr_d = |shr;
        src_d = low;
        perr_d = $countones(prov) > 1;
        state_d = (type_q == 2'b11) ? RESP : (|prov ? XFER : MEM);
      end
      XFER: state_d = RESP;
      MEM: state_d = mem_done ? RESP : MEM;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q <= '0;
      win_q <= '0;
      type_q <= '0;
      addr_q <= '0;
      shr_q <= 1'b0;
      src_q <= '0;
      perr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      win_q <= win_d;
      type_q <= type_d;
      addr_q <= addr_d;
      shr_q <= shr_d;
      src_q <= src_d;
      perr_q <= perr_d;
    end
  end
  assign req_grant = (state_q == SNOOP) ? win_oh : '0;
  assign snoop_valid = state_q == SNOOP;
  assign snoop_type = type_q;
  assign snoop_addr = addr_q;
  assign snoop_target = (state_q == SNOOP) ? ~win_oh : '0;
  assign data_from_cache = state_q == XFER;
  assign data_src = src_q;
  assign mem_req = state_q == MEM;
  assign mem_addr = addr_q;
  assign resp_valid = (state_q == RESP) ? win_oh : '0;
  assign resp_state = (state_q != RESP) ? 3'b000 : (type_q == 2'b01) ? (shr_q ? 3'b101 : 3'b100) : 3'b001;
  assign protocol_err = perr_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// tb_snoop_bus_arbiter: directed scenarios for the snoop-bus arbiter; inputs change and
// outputs are sampled on the falling edge, cycle 0 being the IDLE cycle that presents a request.
module tb_snoop_bus_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] req_valid, req_grant, snoop_target, snp_provide_data, snp_hit, resp_valid;
  logic [7:0] req_type;
  logic [255:0] req_addr;
  logic snoop_valid, data_from_cache, mem_req, mem_done, protocol_err, busy;
  logic [1:0] snoop_type, data_src;
  logic [63:0] snoop_addr, mem_addr;
  logic [2:0] resp_state;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  snoop_bus_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_type(req_type), .req_addr(req_addr),
    .req_grant(req_grant), .snoop_valid(snoop_valid), .snoop_type(snoop_type), .snoop_addr(snoop_addr),
    .snoop_target(snoop_target), .snp_provide_data(snp_provide_data), .snp_hit(snp_hit),
    .data_from_cache(data_from_cache), .data_src(data_src), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_done(mem_done), .resp_valid(resp_valid), .resp_state(resp_state),
    .protocol_err(protocol_err), .busy(busy)
  );
  function automatic logic [63:0] addr_of(input int c);
    return 64'h1234_5678_9ABC_0000 + 64'(c * 64);
  endfunction
  task automatic clr_req();
    req_valid = '0;
    req_type = '0;
    req_addr = '0;
  endtask
  task automatic set_req(input int c, input logic [1:0] t);
    req_valid[c] = 1'b1;
    req_type[2*c +: 2] = t;
    req_addr[64*c +: 64] = addr_of(c);
  endtask
  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
    end
  endtask
  task automatic test_reset();
    tests++;
    if ({busy, snoop_valid, mem_req, data_from_cache, protocol_err, req_grant, resp_valid, resp_state} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: busy=%b sv=%b mreq=%b dfc=%b perr=%b grant=%b resp=%b st=%b, required all 0",
               busy, snoop_valid, mem_req, data_from_cache, protocol_err, req_grant, resp_valid, resp_state);
    end
  endtask
  task automatic test_round_robin();
    int order[$];
    int n = 0;
    for (int c = 0; c < 4; c++) set_req(c, 2'b01);
    mem_done = 1'b1;
    while (order.size() < 5 && n < 60) begin
      @(negedge clk);
      n++;
      if (req_grant != '0) begin
        tests++;
        if ($countones(req_grant) != 1) begin
          fails++;
          $display("FAIL rr_onehot: grant=%b, required one-hot", req_grant);
        end
        order.push_back($clog2(req_grant));
        if (order.size() == 5) clr_req();
      end
    end
    tests++;
    if (order.size() != 5) begin
      fails++;
      $display("FAIL rr_count: %0d grants seen, required 5", order.size());
    end
    for (int i = 0; i < order.size(); i++) begin
      tests++;
      if (order[i] != i % 4) begin
        fails++;
        $display("FAIL rr_order[%0d]: granted core %0d, required core %0d", i, order[i], i % 4);
      end
    end
    clr_req();
    wait_idle();
    mem_done = 1'b0;
  endtask
  task automatic test_mem_read();
    set_req(0, 2'b01);
    @(negedge clk);
    tests++;
    if (req_grant !== 4'b0001 || snoop_target !== 4'b1110 || snoop_type !== 2'b01 || snoop_addr !== addr_of(0)) begin
      fails++;
      $display("FAIL mem_snoop: grant=%b tgt=%b type=%b addr=%h, required 0001 1110 01 %h",
               req_grant, snoop_target, snoop_type, snoop_addr, addr_of(0));
    end
    clr_req();
    for (int cyc = 2; cyc <= 6; cyc++) begin
      @(negedge clk);
      tests++;
      if (mem_req !== 1'b1 || mem_addr !== addr_of(0) || resp_valid !== 4'b0000) begin
        fails++;
        $display("FAIL mem_wait c%0d: mem_req=%b addr=%h resp=%b, required 1 %h 0000",
                 cyc, mem_req, mem_addr, resp_valid, addr_of(0));
      end
      if (cyc == 6) mem_done = 1'b1;
    end
    @(negedge clk);
    mem_done = 1'b0;
    tests++;
    if (resp_valid !== 4'b0001 || resp_state !== 3'b100 || mem_req !== 1'b0) begin
      fails++;
      $display("FAIL mem_resp: resp=%b state=%b mem_req=%b, required 0001 100 0", resp_valid, resp_state, mem_req);
    end
    wait_idle();
  endtask
  task automatic test_cache_xfer();
    set_req(2, 2'b01);
    snp_hit = 4'b0010;
    snp_provide_data = 4'b0110;
    @(negedge clk);
    tests++;
    if (req_grant !== 4'b0100 || snoop_target !== 4'b1011) begin
      fails++;
      $display("FAIL xfer_snoop: grant=%b tgt=%b, required 0100 1011", req_grant, snoop_target);
    end
    clr_req();
    @(negedge clk);
    tests++;
    if (data_from_cache !== 1'b1 || data_src !== 2'd1 || mem_req !== 1'b0 || protocol_err !== 1'b0) begin
      fails++;
      $display("FAIL xfer_data: dfc=%b src=%0d mem_req=%b perr=%b, required 1 1 0 0",
               data_from_cache, data_src, mem_req, protocol_err);
    end
    @(negedge clk);
    tests++;
    if (resp_valid !== 4'b0100 || resp_state !== 3'b101 || mem_req !== 1'b0) begin
      fails++;
      $display("FAIL xfer_resp: resp=%b state=%b mem_req=%b, required 0100 101 0", resp_valid, resp_state, mem_req);
    end
    snp_hit = '0;
    snp_provide_data = '0;
    wait_idle();
  endtask
  task automatic test_upgrade();
    set_req(3, 2'b11);
    snp_hit = 4'b0011;
    @(negedge clk);
    tests++;
    if (req_grant !== 4'b1000 || snoop_target !== 4'b0111 || snoop_valid !== 1'b1) begin
      fails++;
      $display("FAIL upg_snoop: grant=%b tgt=%b sv=%b, required 1000 0111 1", req_grant, snoop_target, snoop_valid);
    end
    clr_req();
    @(negedge clk);
    tests++;
    if (resp_valid !== 4'b1000 || resp_state !== 3'b001 || data_from_cache !== 1'b0 || mem_req !== 1'b0) begin
      fails++;
      $display("FAIL upg_resp: resp=%b state=%b dfc=%b mem_req=%b, required 1000 001 0 0",
               resp_valid, resp_state, data_from_cache, mem_req);
    end
    snp_hit = '0;
    wait_idle();
  endtask
  task automatic test_protocol_err();
    set_req(1, 2'b10);
    snp_provide_data = 4'b0101;
    @(negedge clk);
    tests++;
    if (req_grant !== 4'b0010 || protocol_err !== 1'b0) begin
      fails++;
      $display("FAIL perr_snoop: grant=%b perr=%b, required 0010 0", req_grant, protocol_err);
    end
    clr_req();
    @(negedge clk);
    tests++;
    if (protocol_err !== 1'b1 || data_from_cache !== 1'b1 || data_src !== 2'd0) begin
      fails++;
      $display("FAIL perr_pulse: perr=%b dfc=%b src=%0d, required 1 1 0", protocol_err, data_from_cache, data_src);
    end
    @(negedge clk);
    tests++;
    if (resp_valid !== 4'b0010 || resp_state !== 3'b001 || protocol_err !== 1'b0) begin
      fails++;
      $display("FAIL perr_resp: resp=%b state=%b perr=%b, required 0010 001 0", resp_valid, resp_state, protocol_err);
    end
    snp_provide_data = '0;
    wait_idle();
  endtask
  task automatic test_back_to_back();
    logic [3:0] exp_g [6] = '{4'b0001, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000};
    logic [3:0] exp_r [6] = '{4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0010, 4'b0000};
    set_req(0, 2'b11);
    set_req(1, 2'b11);
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      tests++;
      if (req_grant !== exp_g[cyc-1] || resp_valid !== exp_r[cyc-1]) begin
        fails++;
        $display("FAIL b2b c%0d: grant=%b resp=%b, required %b %b", cyc, req_grant, resp_valid, exp_g[cyc-1], exp_r[cyc-1]);
      end
      if (req_grant[0]) req_valid[0] = 1'b0;
      if (req_grant[1]) req_valid[1] = 1'b0;
    end
    clr_req();
    wait_idle();
  endtask
  task automatic test_reset_mid();
    int seen = 0;
    set_req(2, 2'b01);
    @(negedge clk);
    clr_req();
    @(negedge clk);
    tests++;
    if (mem_req !== 1'b1) begin
      fails++;
      $display("FAIL rst_pre: mem_req=%b, required 1", mem_req);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (mem_req !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rst_async: mem_req=%b busy=%b, required 0 0", mem_req, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mem_done = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (resp_valid !== 4'b0000) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL rst_noresp: resp_valid seen in %0d cycles, required 0", seen);
    end
    set_req(0, 2'b01);
    set_req(3, 2'b01);
    @(negedge clk);
    tests++;
    if (req_grant !== 4'b0001) begin
      fails++;
      $display("FAIL rst_rr: grant=%b, required 0001", req_grant);
    end
    clr_req();
    wait_idle();
    mem_done = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0;
    clr_req();
    snp_hit = '0;
    snp_provide_data = '0;
    mem_done = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_round_robin();
    test_mem_read();
    test_cache_xfer();
    test_upgrade();
    test_protocol_err();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
